// File: rtl/wb_ram_arb_pkg.sv
// Shared definitions for the Wishbone RAM round-robin arbiter.
//   - arb_state_e : arbiter FSM encoding (IDLE / OWN)
//   - CTI_*       : Wishbone B3 cycle-type codes
//   - clog2       : ceiling log2 for sizing pointers and counters
package wb_ram_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_ram_rr_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req : request vector, one bit per master
//   ptr : index of the highest-priority master (must be < NM)
//   gnt : one-hot first set bit of req found scanning upward from ptr,
//         wrapping modulo NM; all zeros when req is empty
module rr_pick #(
  parameter int NM = 4,
  parameter int PW = 2
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] gnt
);

  logic [NM-1:0] rot;
  logic [NM-1:0] first;
  logic          found;

  // Rotate req so ptr lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot   = NM'({req, req} >> ptr);
    first = '0;
    found = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (!found && rot[i]) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
    gnt = NM'(({first, first} << ptr) >> NM);
  end

endmodule

// File: rtl/wb_ram_rr_arb.sv
// wb_ram_rr_arb: registered round-robin arbiter sharing one Wishbone B3
// slave (RAM controller) between nm masters. A grant is held for the whole
// cyc period so bursts are never split; priority rotates past each winner.
//
// Ports
//   wb_clk_i, wb_rst_i            : clock, synchronous active-high reset
//   wbm_*_i                       : packed master requests, master k = slice k
//   wbm_dat_o                     : slave read data broadcast to all masters
//   wbm_ack_o/err_o/rty_o         : per-master responses (rty tied low)
//   wbs_*_o                       : muxed request from the owner, 0 when idle
//   wbs_dat_i/ack_i/err_i         : slave response
//   gnt_o                         : one-hot current grant, 0 when idle
//
// Build option
//   WB_RAM_RR_ARB_WATCHDOG_EN : adds a stall watchdog that answers the owner
//   with err (and masks stb for that cycle) after wd_cycles stalled cycles.
module wb_ram_rr_arb #(
  parameter int nm        = 4,
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int wd_cycles = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [nm*aw-1:0] wbm_adr_i,
  input  logic [nm*dw-1:0] wbm_dat_i,
  input  logic [nm*4-1:0]  wbm_sel_i,
  input  logic [nm*3-1:0]  wbm_cti_i,
  input  logic [nm*2-1:0]  wbm_bte_i,
  input  logic [nm-1:0]    wbm_cyc_i,
  input  logic [nm-1:0]    wbm_stb_i,
  input  logic [nm-1:0]    wbm_we_i,
  output logic [dw-1:0]    wbm_dat_o,
  output logic [nm-1:0]    wbm_ack_o,
  output logic [nm-1:0]    wbm_err_o,
  output logic [nm-1:0]    wbm_rty_o,
  output logic [aw-1:0]    wbs_adr_o,
  output logic [dw-1:0]    wbs_dat_o,
  output logic [3:0]       wbs_sel_o,
  output logic [2:0]       wbs_cti_o,
  output logic [1:0]       wbs_bte_o,
  output logic             wbs_cyc_o,
  output logic             wbs_stb_o,
  output logic             wbs_we_o,
  input  logic [dw-1:0]    wbs_dat_i,
  input  logic             wbs_ack_i,
  input  logic             wbs_err_i,
  output logic [nm-1:0]    gnt_o
);
  import wb_ram_arb_pkg::*;

  localparam int PW = clog2(nm);

  arb_state_e    state_q, state_d;
  logic [nm-1:0] gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [nm-1:0] pick;
  logic [PW-1:0] ptr_nxt;
  logic          own_cyc, own_stb, wd_fire;

  rr_pick #(.NM(nm), .PW(PW)) u_pick (
    .req (wbm_cyc_i),
    .ptr (ptr_q),
    .gnt (pick)
  );

  // Pointer moves to the slot just past the master being granted.
  always_comb begin
    ptr_nxt = '0;
    for (int k = 0; k < nm; k++)
      if (pick[k]) ptr_nxt = PW'((k + 1) % nm);
  end

  // Owner's live cyc/stb; cyc drives release, so the slave sees a drop at once.
  assign own_cyc = |(wbm_cyc_i & gnt_q);
  assign own_stb = |(wbm_stb_i & gnt_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: if (|wbm_cyc_i) begin
        state_d = ST_OWN;
        gnt_d   = pick;
        ptr_d   = ptr_nxt;
      end
      ST_OWN: if (!own_cyc) begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef WB_RAM_RR_ARB_WATCHDOG_EN
  localparam int WCW = clog2(wd_cycles) + 1;
  logic [WCW-1:0] wd_q, wd_d;

  // Counts owner stb cycles without a slave answer; on reaching the limit it
  // answers err itself for one cycle and starts over.
  always_comb begin
    wd_d    = wd_q;
    wd_fire = 1'b0;
    if (state_q != ST_OWN || !own_cyc || wbs_ack_i || wbs_err_i) begin
      wd_d = '0;
    end else if (wd_q == WCW'(wd_cycles)) begin
      wd_fire = 1'b1;
      wd_d    = '0;
    end else if (own_stb) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  // AND-OR mux: gnt_q is one-hot or zero, so idle yields all zeros.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    for (int k = 0; k < nm; k++) begin
      if (gnt_q[k]) begin
        wbs_adr_o = wbs_adr_o | wbm_adr_i[k*aw +: aw];
        wbs_dat_o = wbs_dat_o | wbm_dat_i[k*dw +: dw];
        wbs_sel_o = wbs_sel_o | wbm_sel_i[k*4 +: 4];
        wbs_cti_o = wbs_cti_o | wbm_cti_i[k*3 +: 3];
        wbs_bte_o = wbs_bte_o | wbm_bte_i[k*2 +: 2];
      end
    end
  end

  assign wbs_cyc_o = own_cyc;
  assign wbs_stb_o = own_stb & ~wd_fire;
  assign wbs_we_o  = |(wbm_we_i & gnt_q);

  assign wbm_dat_o = wbs_dat_i;
  assign wbm_ack_o = {nm{wbs_ack_i}} & gnt_q;
  assign wbm_err_o = {nm{wbs_err_i | wd_fire}} & gnt_q;
  assign wbm_rty_o = '0;
  assign gnt_o     = gnt_q;

endmodule

// File: tb/tb_wb_ram_rr_arb.sv
// Directed, self-checking bench for wb_ram_rr_arb (nm=4, wd_cycles=8).
// Expected grant order is queued as requests are raised and popped as
// grants appear. The watchdog expectation follows WB_RAM_RR_ARB_WATCHDOG_EN.
module tb_wb_ram_rr_arb;
  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int WD = 8;
`ifdef WB_RAM_RR_ARB_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM*4-1:0]   m_sel;
  logic [NM*3-1:0]   m_cti;
  logic [NM*2-1:0]   m_bte;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [DW-1:0]     wbm_dat_o;
  logic [NM-1:0]     wbm_ack_o, wbm_err_o, wbm_rty_o, gnt_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [3:0]        wbs_sel_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic              wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [DW-1:0]     s_dat;
  logic              s_ack, s_err;

  wb_ram_rr_arb #(.nm(NM), .dw(DW), .aw(AW), .wd_cycles(WD)) dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .wbm_adr_i(m_adr),     .wbm_dat_i(m_dat),     .wbm_sel_i(m_sel),
    .wbm_cti_i(m_cti),     .wbm_bte_i(m_bte),
    .wbm_cyc_i(m_cyc),     .wbm_stb_i(m_stb),     .wbm_we_i (m_we),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o), .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o), .wbs_we_o (wbs_we_o),
    .wbs_dat_i(s_dat),     .wbs_ack_i(s_ack),     .wbs_err_i(s_err),
    .gnt_o    (gnt_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  int sb[$];

  function automatic logic [NM-1:0] oh(input int k);
    logic [NM-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [AW-1:0] adr_of(input int k);
    return 32'hA000_0000 + 32'(k * 16);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int k, input logic on, input logic [2:0] cti);
    m_cyc[k] = on;
    m_stb[k] = on;
    m_cti[k*3 +: 3] = cti;
  endtask

  // Wait (bounded) for a grant, check it against the queue, do one acked
  // beat, release, and check the dead cycle. Leaves time at the dead cycle.
  task automatic serve_one(input int exp_wait);
    int c;
    int ek;
    c = 0;
    while (gnt_o == '0 && c < 8) begin
      tick();
      c++;
    end
    ek = (sb.size() > 0) ? sb.pop_front() : 0;
    chk("grant_latency", 64'(c), 64'(exp_wait));
    chk("grant_order", 64'(gnt_o), 64'(oh(ek)));
    chk("wbs_adr_mux", 64'(wbs_adr_o), 64'(adr_of(ek)));
    chk("wbs_sel_mux", 64'(wbs_sel_o), 64'(4'(ek + 1)));
    chk("wbs_stb", 64'(wbs_stb_o), 64'd1);
    s_dat = 32'hD000_0000 + 32'(ek);
    s_ack = 1'b1;
    #1;
    chk("ack_gate", 64'(wbm_ack_o), 64'(oh(ek)));
    chk("rd_data", 64'(wbm_dat_o), 64'(32'hD000_0000 + 32'(ek)));
    tick();
    s_ack = 1'b0;
    req(ek, 1'b0, 3'b000);
    #1;
    chk("cyc_release_path", 64'(wbs_cyc_o), 64'd0);
    chk("gnt_hold_release", 64'(gnt_o), 64'(oh(ek)));
    tick();
    chk("dead_cycle", 64'(gnt_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    m_cyc = '0; m_stb = '0; m_we = '0; m_cti = '0; m_bte = '0; m_dat = '0;
    for (int k = 0; k < NM; k++) begin
      m_adr[k*AW +: AW] = adr_of(k);
      m_sel[k*4 +: 4]   = 4'(k + 1);
      m_dat[k*DW +: DW] = 32'h5000_0000 + 32'(k);
      m_bte[k*2 +: 2]   = 2'(k);
    end
    // Reset state, with a request and slave responses present.
    m_cyc[2] = 1'b1;
    s_dat = 32'h1234_5678; s_ack = 1'b1; s_err = 1'b1;
    tick(); tick();
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_wbs_cyc", 64'(wbs_cyc_o), 64'd0);
    chk("rst_wbs_adr", 64'(wbs_adr_o), 64'd0);
    chk("rst_ack", 64'(wbm_ack_o), 64'd0);
    chk("rst_err", 64'(wbm_err_o), 64'd0);
    chk("rst_rty", 64'(wbm_rty_o), 64'd0);
    chk("rst_dat_pass", 64'(wbm_dat_o), 64'h1234_5678);
    m_cyc[2] = 1'b0; s_ack = 1'b0; s_err = 1'b0;
    rst = 1'b0;
    tick();

    // Single request from master 1.
    req(1, 1'b1, 3'b000);
    sb.push_back(1);
    #1;
    chk("single_not_yet", 64'(gnt_o), 64'd0);
    serve_one(1);

    // Contention from a fresh reset: 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NM; k++) req(k, 1'b1, 3'b000);
    sb.push_back(0); sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(0);
    for (int n = 0; n < 5; n++) begin
      int last;
      last = (n == 4) ? 0 : n;
      serve_one(1);
      if (n < 4) req(last, 1'b1, 3'b000);
      else m_cyc = '0;
    end
    m_stb = '0;
    tick();
    chk("idle_no_req", 64'(gnt_o), 64'd0);

    // Burst lock: master 2 bursts 4 beats while master 0 waits.
    req(2, 1'b1, 3'b010);
    sb.push_back(2);
    tick();
    chk("burst_gnt", 64'(gnt_o), 64'(oh(sb.pop_front())));
    req(0, 1'b1, 3'b000);
    sb.push_back(0);
    for (int b = 0; b < 4; b++) begin
      logic [2:0] cti;
      cti = (b == 3) ? 3'b111 : 3'b010;
      m_cti[2*3 +: 3] = cti;
      s_ack = 1'b1;
      #1;
      chk("burst_hold", 64'(gnt_o), 64'(oh(2)));
      chk("burst_cti", 64'(wbs_cti_o), 64'(cti));
      chk("burst_bte", 64'(wbs_bte_o), 64'd2);
      chk("burst_ack", 64'(wbm_ack_o), 64'(oh(2)));
      tick();
    end
    s_ack = 1'b0;
    req(2, 1'b0, 3'b000);
    #1;
    chk("burst_release_hold", 64'(gnt_o), 64'(oh(2)));
    tick();
    chk("burst_dead", 64'(gnt_o), 64'd0);
    tick();
    chk("after_burst", 64'(gnt_o), 64'(oh(sb.pop_front())));

    // Mid-transfer reset while master 3 owns the slave.
    req(0, 1'b0, 3'b000);
    tick();
    req(3, 1'b1, 3'b000);
    tick();
    chk("m3_gnt", 64'(gnt_o), 64'(oh(3)));
    chk("m3_stb", 64'(wbs_stb_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_is_sync", 64'(gnt_o), 64'(oh(3)));
    tick();
    chk("midrst_gnt", 64'(gnt_o), 64'd0);
    chk("midrst_wbs_cyc", 64'(wbs_cyc_o), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < NM; k++) req(k, 1'b1, 3'b000);
    sb.push_back(0);
    tick();
    chk("post_rst_gnt", 64'(gnt_o), 64'(oh(sb.pop_front())));
    m_cyc = '0; m_stb = '0;
    tick(); tick();

    // Watchdog: master 1 is never acked.
    req(1, 1'b1, 3'b000);
    tick();
    for (int i = 0; i < 10; i++) begin
      logic fire;
      fire = WD_ON && (i == WD);
      chk("wd_gnt_held", 64'(gnt_o), 64'(oh(1)));
      chk("wd_err", 64'(wbm_err_o), fire ? 64'(oh(1)) : 64'd0);
      chk("wd_stb", 64'(wbs_stb_o), fire ? 64'd0 : 64'd1);
      tick();
    end
    s_err = 1'b1;
    #1;
    chk("err_pass", 64'(wbm_err_o), 64'(oh(1)));
    tick();
    s_err = 1'b0;
    req(1, 1'b0, 3'b000);
    tick(); tick();
    chk("final_idle", 64'(gnt_o), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
